// File: rtl/crossbar_pkg.sv
// Shared definitions for the crossbar command scheduler: command codes,
// request sources, scheduler states and small helpers.
package crossbar_pkg;

    localparam logic [7:0] CMD_TEMP = 8'h54;  // "T": temperature / moisture poll
    localparam logic [7:0] CMD_DIST = 8'h44;  // "D": distance poll

    localparam logic SRC_HOST = 1'b0;
    localparam logic SRC_AUTO = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE
    } sched_state_t;

    // Only the two poll commands are meaningful to the crossbar.
    function automatic logic is_legal_cmd(input logic [7:0] code);
        return (code == CMD_TEMP) || (code == CMD_DIST);
    endfunction

    // 16-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/poll_tick_gen.sv
// Periodic tick generator for the auto-poll path. Counts 0..POLL_PERIOD-1
// while enabled and emits a one-cycle tick on the terminal count; the
// counter is held at zero whenever the enable is low.
module poll_tick_gen #(
    parameter int POLL_PERIOD = 100_000_000,
    parameter int CNT_W       = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_tick
);

    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(POLL_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    // Free-running period counter, cleared while polling is disabled.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!i_en || (r_cnt == TERMINAL)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    assign o_tick = i_en && (r_cnt == TERMINAL);

endmodule

// File: rtl/crossbar_cmd_scheduler.sv
// Front-end scheduler for the sensor crossbar. Arbitrates a one-deep host
// command slot against the periodic auto-poll request, issues one command
// at a time and follows the ready_to_act handshake to completion, flagging
// a stuck crossbar with a sticky timeout.
// Build option: define SCHED_STATS_EN to enable the saturating issue and
// timeout counters; otherwise stat_issued/stat_timeouts are tied to zero.
module crossbar_cmd_scheduler
    import crossbar_pkg::*;
#(
    parameter int POLL_PERIOD  = 100_000_000,
    parameter int ACK_TIMEOUT  = 16,
    parameter int DONE_TIMEOUT = 50_000_000,
    parameter int CNT_W        = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  host_cmd,
    input  logic        host_cmd_valid,
    output logic        host_cmd_accept,
    output logic        host_cmd_drop,
    input  logic        auto_en,
    input  logic [1:0]  auto_mask,
    input  logic        xb_ready_to_act,
    output logic [7:0]  xb_cmd,
    output logic        xb_valid_command,
    output logic        busy,
    output logic        cmd_done,
    output logic        last_src,
    output logic        timeout_err,
    output logic [15:0] stat_issued,
    output logic [15:0] stat_timeouts
);

    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    sched_state_t     r_state;
    logic             r_slot_full;
    logic [7:0]       r_slot_code;
    logic             r_host_accept;
    logic             r_host_drop;
    logic             r_auto_pending;
    logic             r_auto_next_d;   // alternation pointer: 1 = next auto poll is "D"
    logic             r_pend_src;      // source of the command sitting in ISSUE
    logic [7:0]       r_xb_cmd;
    logic             r_xb_valid;
    logic             r_busy;
    logic             r_cmd_done;
    logic             r_last_src;
    logic             r_timeout_err;
    logic [CNT_W-1:0] r_to_cnt;

    logic       w_auto_active;
    logic       w_tick;
    logic [7:0] w_auto_code;
    logic       w_grant_host;
    logic       w_grant_auto;
    logic       w_ack_timeout;
    logic       w_done_timeout;

    assign w_auto_active = auto_en && (auto_mask != 2'b00);

    poll_tick_gen #(
        .POLL_PERIOD (POLL_PERIOD),
        .CNT_W       (CNT_W)
    ) u_poll_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_auto_active),
        .o_tick (w_tick)
    );

    // Auto target: fixed by a single mask bit, alternating when both are set.
    always_comb begin
        w_auto_code = CMD_TEMP;
        case (auto_mask)
            2'b10:   w_auto_code = CMD_DIST;
            2'b11:   w_auto_code = r_auto_next_d ? CMD_DIST : CMD_TEMP;
            default: w_auto_code = CMD_TEMP;
        endcase
    end

    // Arbitration in IDLE: a lone request wins, contention goes round robin on last_src.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        w_grant_host = 1'b0;
        w_grant_auto = 1'b0;
        if ((r_state == IDLE) && xb_ready_to_act) begin
            if (r_slot_full && r_auto_pending && w_auto_active) begin
                if (r_last_src == SRC_HOST) begin
                    w_grant_auto = 1'b1;
                end else begin
                    w_grant_host = 1'b1;
                end
            end else if (r_slot_full) begin
                w_grant_host = 1'b1;
            end else if (r_auto_pending && w_auto_active) begin
                w_grant_auto = 1'b1;
            end
        end
    end

    assign w_ack_timeout  = (r_state == WAIT_ACK)  &&  xb_ready_to_act && (r_to_cnt == ACK_LAST);
    assign w_done_timeout = (r_state == WAIT_DONE) && !xb_ready_to_act && (r_to_cnt == DONE_LAST);

    // Host slot: latch legal codes into an empty slot; anything else is dropped.
    // A strobe in the cycle the slot is granted still sees it full.
    // NOTE: the data register is reset as well, so nothing downstream ever sees X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot_full   <= 1'b0;
            r_slot_code   <= 8'h00;
            r_host_accept <= 1'b0;
            r_host_drop   <= 1'b0;
        end else begin
            r_host_accept <= 1'b0;
            r_host_drop   <= 1'b0;
            if (w_grant_host) begin
                r_slot_full <= 1'b0;
            end
            if (host_cmd_valid) begin
                if (is_legal_cmd(host_cmd) && !r_slot_full) begin
                    r_slot_full   <= 1'b1;
                    r_slot_code   <= host_cmd;
                    r_host_accept <= 1'b1;
                end else begin
                    r_host_drop <= 1'b1;
                end
            end
        end
    end

    // Auto request flag: set by a tick, cleared on grant or when polling is off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_auto_pending <= 1'b0;
        end else if (!w_auto_active || w_grant_auto) begin
            r_auto_pending <= 1'b0;
        end else if (w_tick) begin
            r_auto_pending <= 1'b1;
        end
    end

    // Command FSM with registered handshake and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_auto_next_d <= 1'b0;
            r_pend_src    <= SRC_HOST;
            r_xb_cmd      <= 8'h00;
            r_xb_valid    <= 1'b0;
            r_busy        <= 1'b0;
            r_cmd_done    <= 1'b0;
            r_last_src    <= SRC_HOST;
            r_timeout_err <= 1'b0;
            r_to_cnt      <= '0;
        end else begin
            r_xb_valid <= 1'b0;
            r_cmd_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_host || w_grant_auto) begin
                        r_xb_cmd   <= w_grant_host ? r_slot_code : w_auto_code;
                        r_pend_src <= w_grant_auto ? SRC_AUTO : SRC_HOST;
                        if (w_grant_auto) begin
                            r_auto_next_d <= (w_auto_code == CMD_TEMP);
                        end
                        r_busy  <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_xb_valid    <= 1'b1;
                    r_last_src    <= r_pend_src;
                    r_timeout_err <= 1'b0;
                    r_to_cnt      <= '0;
                    r_state       <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (!xb_ready_to_act) begin
                        r_to_cnt <= '0;
                        r_state  <= WAIT_DONE;
                    end else if (w_ack_timeout) begin
                        r_timeout_err <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + CNT_ONE;
                    end
                end
                WAIT_DONE: begin
                    if (xb_ready_to_act) begin
                        r_cmd_done <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= IDLE;
                    end else if (w_done_timeout) begin
                        r_timeout_err <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + CNT_ONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign host_cmd_accept  = r_host_accept;
    assign host_cmd_drop    = r_host_drop;
    assign xb_cmd           = r_xb_cmd;
    assign xb_valid_command = r_xb_valid;
    assign busy             = r_busy;
    assign cmd_done         = r_cmd_done;
    assign last_src         = r_last_src;
    assign timeout_err      = r_timeout_err;

`ifdef SCHED_STATS_EN
    logic [15:0] r_stat_issued;
    logic [15:0] r_stat_timeouts;

    // Saturating activity counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_issued   <= 16'h0000;
            r_stat_timeouts <= 16'h0000;
        end else begin
            if (r_state == ISSUE) begin
                r_stat_issued <= sat_inc16(r_stat_issued);
            end
            if (w_ack_timeout || w_done_timeout) begin
                r_stat_timeouts <= sat_inc16(r_stat_timeouts);
            end
        end
    end

    assign stat_issued   = r_stat_issued;
    assign stat_timeouts = r_stat_timeouts;
`else
    assign stat_issued   = 16'h0000;
    assign stat_timeouts = 16'h0000;
`endif

endmodule

// File: doc/crossbar_cmd_scheduler.md
Name: crossbar_cmd_scheduler

Overview:
- Front-end controller for the sensor crossbar: sole driver of the crossbar's command byte and valid_command inputs.
- Arbitrates host UART commands against an internal periodic auto-poll timer.
- Issues one command at a time, then tracks the crossbar's ready_to_act handshake through completion.
- Flags a stuck crossbar with a timeout; the crossbar is never aborted.

Parameters:
POLL_PERIOD, 100_000_000, clk cycles between auto-poll ticks (>=2)
ACK_TIMEOUT, 16, max cycles from issue until ready_to_act falls
DONE_TIMEOUT, 50_000_000, max cycles from ack until ready_to_act rises
CNT_W, 27, width of timer/timeout counters (must hold largest parameter)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
host_cmd  in  8  ASCII command from UART receiver
host_cmd_valid  in  1  one-cycle strobe qualifying host_cmd
host_cmd_accept  out  1  pulse: host command latched
host_cmd_drop  out  1  pulse: host command rejected (illegal code or slot full)
auto_en  in  1  enable periodic polling
auto_mask  in  2  bit0 poll temp/moist ("T"), bit1 poll distance ("D")
xb_ready_to_act  in  1  crossbar idle flag
xb_cmd  out  8  command byte to crossbar
xb_valid_command  out  1  one-cycle issue strobe
busy  out  1  high from ISSUE through WAIT_DONE
cmd_done  out  1  pulse when the crossbar returns to ready
last_src  out  1  source of last issued command: 0 = host, 1 = auto
timeout_err  out  1  sticky; cleared on next issue
stat_issued  out  16  issued-command count (feature only)
stat_timeouts  out  16  timeout count (feature only)

Behaviour:
- Reset: all outputs 0; xb_cmd = 8'h00; state IDLE; host slot and auto_pending empty; poll counter 0.
- Host slot (1 deep): on host_cmd_valid with code 8'h54 or 8'h44 and slot empty, latch the code and pulse host_cmd_accept next cycle.
  - Other codes, or slot full: pulse host_cmd_drop; slot unchanged.
  - A valid strobe in the same cycle the slot is consumed counts as full (dropped).
- Auto-poll timer:
  - When auto_en=1 and auto_mask!=0, count 0..POLL_PERIOD-1. At terminal count: set auto_pending and wrap to 0.
  - A tick while auto_pending is already set is merged.
  - auto_en=0 or auto_mask=0: counter held at 0 and auto_pending cleared (also mid-command; an in-flight command completes).
- Auto target:
  - Alternates "T"/"D" when auto_mask=2'b11; fixed when only one bit is set.
  - The alternation pointer advances only when an auto command is issued.
- FSM: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
  - IDLE: requires xb_ready_to_act=1 and a request. Arbitration:
    - Host only: host wins. Auto only: auto wins.
    - Both pending: the source opposite to last_src wins (round robin).
    - Winner's code is loaded to xb_cmd; that request is cleared; go to ISSUE.
  - ISSUE: xb_valid_command=1 for exactly this one cycle; last_src updated; timeout_err cleared; timeout counter cleared; go to WAIT_ACK. xb_cmd holds its value until the next issue.
  - WAIT_ACK: on xb_ready_to_act=0, go to WAIT_DONE with the counter cleared. If ACK_TIMEOUT cycles elapse first: set timeout_err, go to IDLE.
  - WAIT_DONE: on xb_ready_to_act=1, pulse cmd_done and go to IDLE. If DONE_TIMEOUT cycles elapse first: set timeout_err, go to IDLE, no cmd_done.
  - After a timeout, IDLE still waits for xb_ready_to_act=1 before issuing again.
- Latency: request present in IDLE with the crossbar ready -> strobe 2 cycles later.
- Reset asserted mid-operation: immediate return to reset values; xb_valid_command drops asynchronously.

Optional Feature:
- Macro SCHED_STATS_EN.
- Defined: stat_issued increments at each ISSUE; stat_timeouts increments at each timeout. Both 16-bit, saturating at 16'hFFFF, reset to 0.
- Undefined: ports still present, tied to 0; no counter logic.

Decomposition:
- crossbar_pkg: CMD_TEMP = 8'h54, CMD_DIST = 8'h44, enum sched_state_t {IDLE, ISSUE, WAIT_ACK, WAIT_DONE}, SRC_HOST = 1'b0, SRC_AUTO = 1'b1.
- One sub-module, poll_tick_gen: counter plus enable, one-cycle tick output, parameterised by POLL_PERIOD and CNT_W.

Test Plan:
- Host path (POLL_PERIOD=20, auto_en=0, crossbar model acks 1 cycle after strobe, completes 10 cycles later):
  - host_cmd=8'h54 strobe -> accept pulse, xb_cmd=8'h54 with a 1-cycle strobe 2 cycles later, cmd_done after completion, last_src=0.
- Illegal and overflow:
  - host_cmd=8'h41 -> drop pulse, no issue.
  - Two legal strobes while busy -> first accepted, second dropped.
- Auto alternation (auto_en=1, auto_mask=2'b11, POLL_PERIOD=20):
  - Commands issued in order 54, 44, 54 at ~20-cycle spacing.
  - auto_mask=2'b10 -> only 44.
- Contention: host "D" and auto tick pending in the same IDLE cycle with last_src=1 -> host issued first, auto next; then the reverse case.
- Timeouts (ACK_TIMEOUT=16, DONE_TIMEOUT=40):
  - Crossbar never drops ready -> timeout_err after 16 cycles, no cmd_done.
  - Crossbar stuck low -> timeout_err after 40 cycles; no issue until ready returns; next issue clears timeout_err.
- Reset mid-WAIT_DONE: rst pulse -> all outputs 0 immediately.
  - With SCHED_STATS_EN: stat_issued=3 after three issues; stat_timeouts=1 after one timeout.
